// File: rtl/fixed_round_arbiter.sv
// fixed_round_arbiter: round-robin share of one registered fixed-point
// round-half-even/saturate stage between N_REQ valid/ready streams.
module fixed_round_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 3,
    parameter int OUT_WIDTH      = 4,
    parameter int OUT_FRAC_WIDTH = 1,
    parameter int ID_WIDTH       = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*IN_WIDTH-1:0] data_in,
    input  logic [N_REQ-1:0]          data_in_valid,
    output logic [N_REQ-1:0]          data_in_ready,
    output logic [OUT_WIDTH-1:0]      data_out,
    output logic [ID_WIDTH-1:0]       data_out_id,
    output logic                      data_out_sat,
    output logic                      data_out_valid,
    input  logic                      data_out_ready
);
    localparam int S  = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int XW = IN_WIDTH + 1;
    localparam logic signed [XW-1:0] MAX_V = XW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

    logic [ID_WIDTH-1:0]  last, grant, a_id;
    logic [IN_WIDTH-1:0]  sel_data, a_data;
    logic                 found, a_valid, a_accept, b_accept, take, inc, hi, lo;
    logic signed [XW-1:0] x, q, qr;
    logic [OUT_WIDTH-1:0] rounded;

    // first valid requester after the last accepted one, with wrap
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(last) + 1 + k) % N_REQ;
            if (!found && data_in_valid[idx]) begin
                found    = 1'b1;
                grant    = ID_WIDTH'(idx);
                sel_data = data_in[idx*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    assign b_accept      = !data_out_valid || data_out_ready;
    assign a_accept      = !a_valid || b_accept;
    assign take          = found && a_accept && !rst;
    assign data_in_ready = take ? N_REQ'(1) << grant : '0;

    assign x  = {a_data[IN_WIDTH-1], a_data};
    assign q  = x >>> S;
    assign qr = q + XW'(inc);

    generate
        if (S > 0) begin : g_round
            localparam logic [S-1:0] HALF = S'(1) << (S - 1);
            logic [S-1:0] r;
            assign r   = a_data[S-1:0];
            assign inc = (r > HALF) || (r == HALF && q[0]);
        end else begin : g_trunc
            assign inc = 1'b0;
        end
    endgenerate

    assign hi      = qr > MAX_V;
    assign lo      = qr < MIN_V;
    assign rounded = hi ? MAX_V[OUT_WIDTH-1:0] : lo ? MIN_V[OUT_WIDTH-1:0] : qr[OUT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last           <= ID_WIDTH'(N_REQ - 1);
            a_valid        <= 1'b0;
            a_data         <= '0;
            a_id           <= '0;
            data_out       <= '0;
            data_out_id    <= '0;
            data_out_sat   <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            if (take)
                last <= grant;
            if (a_accept) begin
                a_valid <= take;
                a_data  <= sel_data;
                a_id    <= grant;
            end
            if (b_accept) begin
                data_out_valid <= a_valid;
                if (a_valid) begin
                    data_out     <= rounded;
                    data_out_id  <= a_id;
                    data_out_sat <= hi || lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_round_arbiter.sv
// tb_fixed_round_arbiter: random and directed streams checked each cycle
// against an arithmetic reference of arbitration, pipeline and rounding.
module tb_fixed_round_arbiter;
    logic        clk = 0, rst = 1, ordy = 0;
    logic [31:0] din = '0;
    logic [3:0]  vld = '0, data_in_ready;
    logic [3:0]  data_out;
    logic [1:0]  data_out_id;
    logic        data_out_sat, data_out_valid;

    int n_chk = 0, n_fail = 0;

    fixed_round_arbiter dut (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vld),
        .data_in_ready(data_in_ready), .data_out(data_out), .data_out_id(data_out_id),
        .data_out_sat(data_out_sat), .data_out_valid(data_out_valid), .data_out_ready(ordy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // {sat, data}: value/8 rescaled to /2 with round half to even, then clamp
    function automatic logic [4:0] rnd(input logic [7:0] xb);
        int v, r, q;
        v = int'($signed(xb));
        r = ((v % 4) + 4) % 4;
        q = (v - r) / 4;
        if (r > 2 || (r == 2 && (q % 2) != 0)) q++;
        if (q > 7) return 5'h17;
        if (q < -8) return 5'h18;
        return {1'b0, 4'(q)};
    endfunction

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 0; k < 4; k++)
            if (v[(last + 1 + k) % 4]) return (last + 1 + k) % 4;
        return -1;
    endfunction

    // reference state
    int         m_last, m_g, ma_id, mb_id;
    logic       ma_v, mb_v, m_bmove, m_amove;
    logic [7:0] ma_x;
    logic [4:0] mb_out;
    logic [3:0] m_rdy, m_took;
    logic [9:0] accq[$], sent[$];
    logic [6:0] out_log[$];

    always_comb begin
        m_g     = pick(vld, m_last);
        m_bmove = !mb_v || ordy;
        m_amove = !ma_v || m_bmove;
        m_rdy   = (!rst && m_g >= 0 && m_amove) ? 4'(1 << m_g) : 4'd0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last <= 3; ma_v <= 0; mb_v <= 0; mb_out <= 0; mb_id <= 0;
            ma_x <= 0; ma_id <= 0; m_took <= 0;
            accq.delete();
        end else begin
            if (m_bmove) begin
                mb_v <= ma_v;
                if (ma_v) begin
                    mb_out <= rnd(ma_x);
                    mb_id  <= ma_id;
                end
            end
            if (m_amove) begin
                ma_v <= (m_g >= 0);
                if (m_g >= 0) begin
                    ma_x  <= din[m_g*8 +: 8];
                    ma_id <= m_g;
                end
            end
            m_took <= m_rdy;
            if (m_rdy != 0) m_last <= m_g;
            if (mb_v && ordy) void'(accq.pop_front());
            if (m_rdy != 0) accq.push_back({2'(m_g), din[m_g*8 +: 8]});
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        logic [6:0] exp_head;
        chk("ready", data_in_ready, m_rdy);
        chk("ready_nonvalid", data_in_ready & ~vld, 0);
        chk("out_valid", data_out_valid, mb_v);
        if (mb_v) begin
            chk("data", data_out, mb_out[3:0]);
            chk("sat", data_out_sat, mb_out[4]);
            chk("id", data_out_id, mb_id);
            exp_head = accq.size() > 0 ? {accq[0][9:8], rnd(accq[0][7:0])} : 7'h7f;
            chk("order", {data_out_id, data_out_sat, data_out}, exp_head);
        end
        if (data_out_valid && ordy) out_log.push_back({data_out_id, data_out_sat, data_out});
    end

    task automatic step(input int pct);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (m_took[i]) begin
                sent.push_back({2'(i), din[i*8 +: 8]});
                din[i*8 +: 8] = 8'($urandom);
                if (pct >= 0) vld[i] = 0;
            end
            if (pct >= 0 && !vld[i]) vld[i] = ($urandom_range(0, 99) < pct);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        vld = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        sent.delete();
        out_log.delete();
    endtask

    task automatic verify_log(input string n);
        chk({n, "_count"}, out_log.size(), sent.size());
        for (int j = 0; j < out_log.size() && j < sent.size(); j++)
            chk({n, "_item"}, out_log[j], {sent[j][9:8], rnd(sent[j][7:0])});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rv[6];
        logic [4:0] re[6];
        int k;
        rv = '{8'h06, 8'h02, 8'h0A, 8'hFA, 8'h64, 8'h80};
        re = '{5'h02, 5'h00, 5'h02, 5'h0E, 5'h17, 5'h18};
        din = $urandom;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", {data_out_id, data_out_sat, data_out}, 0);
        chk("rst_ready", data_in_ready, 0);
        for (int j = 0; j < 6; j++) chk("model_rnd", rnd(rv[j]), re[j]);

        // rounding vectors through requester 0
        do_reset();
        ordy = 1;
        vld[0] = 1;
        din[7:0] = rv[0];
        k = 0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            @(posedge clk);
            #1;
            if (m_took[0]) begin
                k++;
                if (k < 6) din[7:0] = rv[k];
                else vld[0] = 0;
            end
        end
        repeat (4) @(posedge clk);
        chk("rnd_count", out_log.size(), 6);
        for (int j = 0; j < out_log.size() && j < 6; j++) chk("rnd_dut", out_log[j][4:0], re[j]);

        // fairness with all four requesters valid
        do_reset();
        vld = 4'hF;
        repeat (8) step(-1);
        repeat (8) step(0);
        for (int j = 0; j < out_log.size() && j < 8; j++) chk("rr_id", out_log[j][6:5], j % 4);
        verify_log("rr");

        // pointer hold with requesters 1 and 3, then 1 drops out
        do_reset();
        vld = 4'b1010;
        repeat (3) step(-1);
        vld[1] = 0;
        repeat (5) step(-1);
        repeat (4) step(0);
        begin
            int ids[8] = '{1, 3, 1, 3, 3, 3, 3, 3};
            for (int j = 0; j < out_log.size() && j < 8; j++) chk("ptr_id", out_log[j][6:5], ids[j]);
        end
        verify_log("ptr");

        // backpressure on requester 2
        do_reset();
        vld = 4'b0100;
        repeat (3) step(-1);
        ordy = 0;
        #1;
        chk("bp_ready_low", data_in_ready, 0);
        chk("bp_out_valid", data_out_valid, 1);
        repeat (3) step(-1);
        ordy = 1;
        repeat (4) step(-1);
        repeat (4) step(0);
        verify_log("bp");

        // async reset with both stages full
        do_reset();
        vld = 4'hF;
        repeat (4) step(-1);
        @(posedge clk);
        #2;
        chk("pre_arst_valid", data_out_valid, 1);
        #1;
        rst = 1;
        #1;
        chk("arst_valid", data_out_valid, 0);
        chk("arst_ready", data_in_ready, 0);
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        chk("first_grant", data_in_ready, 4'b0001);

        // randomized valids and downstream ready
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step(c < 1500 ? 30 : 90);
            ordy = ($urandom_range(0, 9) < 7);
        end
        ordy = 1;
        repeat (40) step(0);
        chk("rand_drained_q", accq.size(), 0);
        chk("rand_drained_vld", vld, 0);
        verify_log("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
